// File: rtl/iir_sos_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : iir_sos_sequencer                                               |
// | Brief    : Control FSM stepping a shared biquad through a cascade of SOS.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module iir_sos_sequencer #(
  parameter int NUMBER  = 4,
  parameter int TAPSIZE = 3,
  parameter int SOS_LAT = 1,
  localparam int SEC_W   = (NUMBER > 1) ? $clog2(NUMBER) : 1,
  localparam int COEF_W  = ((NUMBER * 2 * TAPSIZE) > 1) ? $clog2(NUMBER * 2 * TAPSIZE) : 1,
  localparam int SCALE_W = $clog2(NUMBER + 1)
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               CE,
  input  logic               din_valid,
  output logic               din_ready,
  output logic               din_load,
  output logic               busy,
  output logic [SEC_W-1:0]   sec_idx,
  output logic [COEF_W-1:0]  coef_base,
  output logic [SCALE_W-1:0] scale_addr,
  output logic               mux_sel,
  output logic               sec_we,
  output logic               out_we,
  input  logic               ovf_in,
  output logic               dout_valid,
  output logic               ovf_out
);

  localparam int LAT_W = (SOS_LAT > 1) ? $clog2(SOS_LAT) : 1;

  localparam logic [SEC_W-1:0]   c_LAST_SEC   = SEC_W'(NUMBER - 1);
  localparam logic [SEC_W-1:0]   c_SEC_ONE    = SEC_W'(1);
  localparam logic [LAT_W-1:0]   c_LAST_LAT   = LAT_W'(SOS_LAT - 1);
  localparam logic [LAT_W-1:0]   c_LAT_ONE    = LAT_W'(1);
  localparam logic [COEF_W-1:0]  c_SEC_STRIDE = COEF_W'(2 * TAPSIZE);
  localparam logic [SCALE_W-1:0] c_SCALE_OUT  = SCALE_W'(NUMBER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEC_W-1:0]   r_sec;
  logic [SEC_W-1:0]   w_sec_nxt;
  logic [LAT_W-1:0]   r_lat;
  logic [LAT_W-1:0]   w_lat_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic               r_ovf_out;
  logic               w_ovf_out_nxt;
  logic               r_dout_valid;
  logic               w_dout_valid_nxt;
  logic               w_lat_done;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_sec        <= '0;
      r_lat        <= '0;
      r_ovf        <= 1'b0;
      r_ovf_out    <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sec        <= w_sec_nxt;
      r_lat        <= w_lat_nxt;
      r_ovf        <= w_ovf_nxt;
      r_ovf_out    <= w_ovf_out_nxt;
      r_dout_valid <= w_dout_valid_nxt;
    end
  end

  // Every register update below is gated by CE, so CE=0 freezes the whole sequencer.
  always_comb begin
    w_state_nxt      = r_state;
    w_sec_nxt        = r_sec;
    w_lat_nxt        = r_lat;
    w_ovf_nxt        = r_ovf;
    w_ovf_out_nxt    = r_ovf_out;
    w_dout_valid_nxt = r_dout_valid;
    w_lat_done       = (r_lat == c_LAST_LAT);
    din_ready        = 1'b0;
    din_load         = 1'b0;
    coef_base        = '0;
    scale_addr       = '0;
    mux_sel          = 1'b0;
    sec_we           = 1'b0;
    out_we           = 1'b0;

    case (r_state)
      S_IDLE: begin
        din_ready = CE;
        din_load  = CE & din_valid & ~Reset;
        if (CE) begin
          w_dout_valid_nxt = 1'b0;
          if (din_valid) begin
            w_state_nxt   = S_RUN;
            w_sec_nxt     = '0;
            w_lat_nxt     = '0;
            w_ovf_nxt     = 1'b0;
            w_ovf_out_nxt = 1'b0;
          end
        end
      end

      S_RUN: begin
        scale_addr = SCALE_W'(r_sec);
        coef_base  = COEF_W'(r_sec) * c_SEC_STRIDE;
        mux_sel    = (r_sec != '0);
        if (CE) begin
          w_dout_valid_nxt = 1'b0;
          w_ovf_nxt        = r_ovf | ovf_in;
          sec_we           = w_lat_done;
          if (w_lat_done) begin
            w_lat_nxt = '0;
            if (r_sec == c_LAST_SEC) begin
              w_state_nxt = S_OUT;
            end else begin
              w_sec_nxt = r_sec + c_SEC_ONE;
            end
          end else begin
            w_lat_nxt = r_lat + c_LAT_ONE;
          end
        end
      end

      S_OUT: begin
        scale_addr = c_SCALE_OUT;
        mux_sel    = 1'b1;
        if (CE) begin
          out_we           = 1'b1;
          // The reported flag includes an overflow raised during the output scaling itself.
          w_ovf_nxt        = r_ovf | ovf_in;
          w_ovf_out_nxt    = r_ovf | ovf_in;
          w_dout_valid_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
          w_sec_nxt        = '0;
          w_lat_nxt        = '0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy       = (r_state != S_IDLE);
  assign sec_idx    = r_sec;
  assign dout_valid = r_dout_valid;
  assign ovf_out    = r_ovf_out;

endmodule
`default_nettype wire
